// File: rtl/lc4_pkg.sv
// Shared constants and helpers for the LC4 decode stage.
package lc4_pkg;

  localparam logic [15:0] NOP_INSN    = 16'h0000;
  localparam int          REG_IDX_W   = 3;
  localparam int          STALL_CNT_W = 16;

  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // A source read conflicts with a producer register when it is actually read
  // and the indices match. R0 is general-purpose in LC4, so it is not special-cased.
  function automatic logic reg_match(input logic re, input reg_idx_t src, input reg_idx_t dst);
    return re & (src == dst);
  endfunction

endpackage

// File: rtl/lc4_dx_latch.sv
// D/X pipeline latch: asynchronous active-low clear, gwe-qualified load.
// bubble_i replaces the captured instruction with a NOP bubble.
module lc4_dx_latch
  import lc4_pkg::*;
#(
  parameter int n = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           gwe,
  input  logic           bubble_i,
  input  logic           d_valid_i,
  input  logic [15:0]    d_pc_i,
  input  logic [15:0]    d_insn_i,
  input  reg_idx_t       d_rs_i,
  input  reg_idx_t       d_rt_i,
  input  reg_idx_t       d_rd_i,
  input  logic           d_rd_we_i,
  input  logic           d_is_load_i,
  input  logic [n-1:0]   d_rs_data_i,
  input  logic [n-1:0]   d_rt_data_i,
  output logic           x_valid_o,
  output logic [15:0]    x_pc_o,
  output logic [15:0]    x_insn_o,
  output reg_idx_t       x_rs_o,
  output reg_idx_t       x_rt_o,
  output reg_idx_t       x_rd_o,
  output logic           x_rd_we_o,
  output logic           x_is_load_o,
  output logic [n-1:0]   x_rs_data_o,
  output logic [n-1:0]   x_rt_data_o
);

  logic         valid_q,   valid_d;
  logic [15:0]  pc_q,      pc_d;
  logic [15:0]  insn_q,    insn_d;
  reg_idx_t     rs_q,      rs_d;
  reg_idx_t     rt_q,      rt_d;
  reg_idx_t     rd_q,      rd_d;
  logic         rd_we_q,   rd_we_d;
  logic         is_load_q, is_load_d;
  logic [n-1:0] rs_data_q, rs_data_d;
  logic [n-1:0] rt_data_q, rt_data_d;

  // Next latch contents: hold without gwe, bubble on request, else capture.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    insn_d    = insn_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    is_load_d = is_load_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    if (gwe) begin
      if (bubble_i) begin
        valid_d   = 1'b0;
        pc_d      = '0;
        insn_d    = NOP_INSN;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        rd_we_d   = 1'b0;
        is_load_d = 1'b0;
        rs_data_d = '0;
        rt_data_d = '0;
      end else begin
        valid_d   = d_valid_i;
        pc_d      = d_pc_i;
        insn_d    = d_insn_i;
        rs_d      = d_rs_i;
        rt_d      = d_rt_i;
        rd_d      = d_rd_i;
        // An invalid slot must never look like a producer to the hazard check.
        rd_we_d   = d_rd_we_i & d_valid_i;
        is_load_d = d_is_load_i & d_valid_i;
        rs_data_d = d_rs_data_i;
        rt_data_d = d_rt_data_i;
      end
    end
  end

  // Latch registers, cleared to a bubble while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      insn_q    <= NOP_INSN;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      is_load_q <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      insn_q    <= insn_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      is_load_q <= is_load_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
    end
  end

  assign x_valid_o   = valid_q;
  assign x_pc_o      = pc_q;
  assign x_insn_o    = insn_q;
  assign x_rs_o      = rs_q;
  assign x_rt_o      = rt_q;
  assign x_rd_o      = rd_q;
  assign x_rd_we_o   = rd_we_q;
  assign x_is_load_o = is_load_q;
  assign x_rs_data_o = rs_data_q;
  assign x_rt_data_o = rt_data_q;

endmodule

// File: rtl/lc4_decode_stage.sv
// LC4 decode stage: load-use hazard detection, stall counter, optional
// Writeback-to-Decode bypass, and the D/X latch.
// Build option: define LC4_WD_BYPASS_EN to forward the Writeback value into
// the captured register data when it targets a Decode source register.
module lc4_decode_stage
  import lc4_pkg::*;
#(
  parameter int n = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gwe,
  input  logic                   i_d_valid,
  input  logic [15:0]            i_d_pc,
  input  logic [15:0]            i_d_insn,
  input  logic [REG_IDX_W-1:0]   i_d_rs,
  input  logic [REG_IDX_W-1:0]   i_d_rt,
  input  logic [REG_IDX_W-1:0]   i_d_rd,
  input  logic                   i_d_rs_re,
  input  logic                   i_d_rt_re,
  input  logic                   i_d_rd_we,
  input  logic                   i_d_is_load,
  input  logic [n-1:0]           i_rs_data,
  input  logic [n-1:0]           i_rt_data,
  input  logic [REG_IDX_W-1:0]   i_w_rd,
  input  logic                   i_w_rd_we,
  input  logic [n-1:0]           i_w_wdata,
  input  logic                   i_flush,
  output logic                   o_x_valid,
  output logic [15:0]            o_x_pc,
  output logic [15:0]            o_x_insn,
  output logic [REG_IDX_W-1:0]   o_x_rs,
  output logic [REG_IDX_W-1:0]   o_x_rt,
  output logic [REG_IDX_W-1:0]   o_x_rd,
  output logic                   o_x_rd_we,
  output logic                   o_x_is_load,
  output logic [n-1:0]           o_x_rs_data,
  output logic [n-1:0]           o_x_rt_data,
  output logic                   o_stall,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  logic                   load_use;
  logic                   bubble;
  logic [n-1:0]           rs_data_fwd;
  logic [n-1:0]           rt_data_fwd;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Load in X whose result a valid Decode instruction needs next cycle.
  always_comb begin
    load_use = o_x_valid & o_x_is_load & o_x_rd_we & i_d_valid &
               (reg_match(i_d_rs_re, i_d_rs, o_x_rd) | reg_match(i_d_rt_re, i_d_rt, o_x_rd));
  end

  // A flush kills Decode outright, so it masks any stall for that cycle.
  assign o_stall = load_use & ~i_flush;
  assign bubble  = i_flush | o_stall;

`ifdef LC4_WD_BYPASS_EN
  // Forward the value being written this cycle onto matching source reads.
  always_comb begin
    rs_data_fwd = (i_w_rd_we && (i_w_rd == i_d_rs)) ? i_w_wdata : i_rs_data;
    rt_data_fwd = (i_w_rd_we && (i_w_rd == i_d_rt)) ? i_w_wdata : i_rt_data;
  end
`else
  // Register file provides write-before-read; the write port is informational only.
  logic unused_wb_port;
  assign unused_wb_port = ^{i_w_rd, i_w_rd_we, i_w_wdata};

  always_comb begin
    rs_data_fwd = i_rs_data;
    rt_data_fwd = i_rt_data;
  end
`endif

  // Saturating count of stall cycles actually taken (gwe edges only).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (gwe && o_stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;

  lc4_dx_latch #(.n(n)) u_dx_latch (
    .clk         (clk),
    .rst         (rst),
    .gwe         (gwe),
    .bubble_i    (bubble),
    .d_valid_i   (i_d_valid),
    .d_pc_i      (i_d_pc),
    .d_insn_i    (i_d_insn),
    .d_rs_i      (i_d_rs),
    .d_rt_i      (i_d_rt),
    .d_rd_i      (i_d_rd),
    .d_rd_we_i   (i_d_rd_we),
    .d_is_load_i (i_d_is_load),
    .d_rs_data_i (rs_data_fwd),
    .d_rt_data_i (rt_data_fwd),
    .x_valid_o   (o_x_valid),
    .x_pc_o      (o_x_pc),
    .x_insn_o    (o_x_insn),
    .x_rs_o      (o_x_rs),
    .x_rt_o      (o_x_rt),
    .x_rd_o      (o_x_rd),
    .x_rd_we_o   (o_x_rd_we),
    .x_is_load_o (o_x_is_load),
    .x_rs_data_o (o_x_rs_data),
    .x_rt_data_o (o_x_rt_data)
  );

endmodule

// File: tb/tb_lc4_decode_stage.sv
// Bench for lc4_decode_stage: directed hazard/flush/bypass/hold/reset/saturation
// cases plus randomized cycles against a reference model of the pipeline latch.
module tb_lc4_decode_stage;

  logic        clk, rst, gwe;
  logic        i_d_valid;
  logic [15:0] i_d_pc, i_d_insn;
  logic [2:0]  i_d_rs, i_d_rt, i_d_rd;
  logic        i_d_rs_re, i_d_rt_re, i_d_rd_we, i_d_is_load;
  logic [15:0] i_rs_data, i_rt_data;
  logic [2:0]  i_w_rd;
  logic        i_w_rd_we;
  logic [15:0] i_w_wdata;
  logic        i_flush;
  logic        o_x_valid;
  logic [15:0] o_x_pc, o_x_insn;
  logic [2:0]  o_x_rs, o_x_rt, o_x_rd;
  logic        o_x_rd_we, o_x_is_load;
  logic [15:0] o_x_rs_data, o_x_rt_data;
  logic        o_stall;
  logic [15:0] o_stall_cnt;

  lc4_decode_stage #(.n(16)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_d_valid(i_d_valid), .i_d_pc(i_d_pc), .i_d_insn(i_d_insn),
    .i_d_rs(i_d_rs), .i_d_rt(i_d_rt), .i_d_rd(i_d_rd),
    .i_d_rs_re(i_d_rs_re), .i_d_rt_re(i_d_rt_re), .i_d_rd_we(i_d_rd_we),
    .i_d_is_load(i_d_is_load), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_w_rd(i_w_rd), .i_w_rd_we(i_w_rd_we), .i_w_wdata(i_w_wdata),
    .i_flush(i_flush),
    .o_x_valid(o_x_valid), .o_x_pc(o_x_pc), .o_x_insn(o_x_insn),
    .o_x_rs(o_x_rs), .o_x_rt(o_x_rt), .o_x_rd(o_x_rd),
    .o_x_rd_we(o_x_rd_we), .o_x_is_load(o_x_is_load),
    .o_x_rs_data(o_x_rs_data), .o_x_rt_data(o_x_rt_data),
    .o_stall(o_stall), .o_stall_cnt(o_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model of the D/X latch and stall counter
  logic        m_valid, m_rd_we, m_is_load;
  logic [15:0] m_pc, m_insn, m_rs_data, m_rt_data, m_cnt;
  logic [2:0]  m_rs, m_rt, m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_insn = 16'h0000; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rd_we = 0; m_is_load = 0; m_rs_data = 0; m_rt_data = 0; m_cnt = 0;
  endtask

  function automatic logic model_hazard();
    logic rs_hit, rt_hit;
    rs_hit = i_d_rs_re && (i_d_rs == m_rd);
    rt_hit = i_d_rt_re && (i_d_rt == m_rd);
    return m_valid && m_is_load && m_rd_we && i_d_valid && (rs_hit || rt_hit);
  endfunction

  task automatic model_edge(input logic stall);
    logic [15:0] rs_v, rt_v;
    if (!gwe) return;
    if (stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (i_flush || stall) begin
      m_valid = 0; m_pc = 0; m_insn = 16'h0000; m_rs = 0; m_rt = 0; m_rd = 0;
      m_rd_we = 0; m_is_load = 0; m_rs_data = 0; m_rt_data = 0;
    end else begin
      rs_v = i_rs_data;
      rt_v = i_rt_data;
`ifdef LC4_WD_BYPASS_EN
      if (i_w_rd_we && i_w_rd == i_d_rs) rs_v = i_w_wdata;
      if (i_w_rd_we && i_w_rd == i_d_rt) rt_v = i_w_wdata;
`endif
      m_valid = i_d_valid; m_pc = i_d_pc; m_insn = i_d_insn;
      m_rs = i_d_rs; m_rt = i_d_rt; m_rd = i_d_rd;
      m_rd_we = i_d_valid ? i_d_rd_we : 1'b0;
      m_is_load = i_d_valid ? i_d_is_load : 1'b0;
      m_rs_data = rs_v; m_rt_data = rt_v;
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".valid"},   o_x_valid,   m_valid);
    check({pfx, ".pc"},      o_x_pc,      m_pc);
    check({pfx, ".insn"},    o_x_insn,    m_insn);
    check({pfx, ".rs"},      o_x_rs,      m_rs);
    check({pfx, ".rt"},      o_x_rt,      m_rt);
    check({pfx, ".rd"},      o_x_rd,      m_rd);
    check({pfx, ".rd_we"},   o_x_rd_we,   m_rd_we);
    check({pfx, ".is_load"}, o_x_is_load, m_is_load);
    check({pfx, ".rs_data"}, o_x_rs_data, m_rs_data);
    check({pfx, ".rt_data"}, o_x_rt_data, m_rt_data);
    check({pfx, ".cnt"},     o_stall_cnt, m_cnt);
  endtask

  // Called at posedge+1 with inputs already applied; ends at the next posedge+1.
  task automatic cycle(input string pfx);
    logic exp_stall;
    exp_stall = model_hazard() && !i_flush;
    #3;
    check({pfx, ".stall"}, o_stall, exp_stall);
    @(posedge clk); #1;
    model_edge(exp_stall);
    check_outputs(pfx);
  endtask

  task automatic set_d(input logic v, input logic [2:0] rs, input logic rs_re,
                       input logic [2:0] rt, input logic rt_re, input logic [2:0] rd,
                       input logic rd_we, input logic ld);
    i_d_valid = v; i_d_rs = rs; i_d_rs_re = rs_re; i_d_rt = rt; i_d_rt_re = rt_re;
    i_d_rd = rd; i_d_rd_we = rd_we; i_d_is_load = ld;
    i_d_pc = 16'($urandom); i_d_insn = 16'($urandom);
    i_rs_data = 16'($urandom); i_rt_data = 16'($urandom);
    i_w_rd_we = 0; i_w_rd = 0; i_w_wdata = 0;
    gwe = 1; i_flush = 0;
  endtask

  task automatic randomize_inputs();
    i_d_valid = ($urandom_range(0, 3) != 0);
    i_d_rs = 3'($urandom_range(0, 3)); i_d_rt = 3'($urandom_range(0, 3));
    i_d_rd = 3'($urandom_range(0, 3));
    i_d_rs_re = 1'($urandom); i_d_rt_re = 1'($urandom);
    i_d_rd_we = ($urandom_range(0, 3) != 0); i_d_is_load = 1'($urandom);
    i_d_pc = 16'($urandom); i_d_insn = 16'($urandom);
    i_rs_data = 16'($urandom); i_rt_data = 16'($urandom);
    i_w_rd = 3'($urandom_range(0, 3)); i_w_rd_we = 1'($urandom);
    i_w_wdata = 16'($urandom);
    gwe = ($urandom_range(0, 7) != 0);
    i_flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    rst = 0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check("rst0.valid", o_x_valid, 0);
    check("rst0.insn", o_x_insn, 16'h0000);
    check("rst0.cnt", o_stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1;

    // load-use: load r3 into X, then a reader of r3
    set_d(1, 0, 0, 0, 0, 3, 1, 1);
    cycle("lu_ld");
    set_d(1, 3, 1, 1, 0, 4, 1, 0);
    #3;
    check("lu.stall", o_stall, 1);
    #0 ;
    @(posedge clk); #1;
    model_edge(1'b1);
    check("lu.bubble", o_x_valid, 0);
    check("lu.cnt", o_stall_cnt, 16'd1);
    check_outputs("lu");

    // flush priority over the same hazard
    set_d(1, 0, 0, 0, 0, 3, 1, 1);
    cycle("fl_ld");
    set_d(1, 3, 1, 1, 0, 4, 1, 0);
    i_flush = 1;
    #3;
    check("fl.stall", o_stall, 0);
    @(posedge clk); #1;
    model_edge(1'b0);
    check("fl.bubble", o_x_valid, 0);
    check("fl.cnt", o_stall_cnt, 16'd1);
    check_outputs("fl");

    // R0 hazards are real
    set_d(1, 0, 0, 0, 0, 0, 1, 1);
    cycle("r0_ld");
    set_d(1, 5, 0, 0, 1, 2, 1, 0);
    cycle("r0_use");
    check("r0.cnt", o_stall_cnt, 16'd2);

    // writeback bypass on rt
    set_d(1, 1, 1, 5, 1, 2, 1, 0);
    i_rt_data = 16'h1234; i_w_rd = 5; i_w_rd_we = 1; i_w_wdata = 16'hBEEF;
    cycle("byp");
`ifdef LC4_WD_BYPASS_EN
    check("byp.rt_data", o_x_rt_data, 16'hBEEF);
`else
    check("byp.rt_data", o_x_rt_data, 16'h1234);
`endif

    // gwe hold: X holds a load of r3, three edges with gwe=0 and a hazard present
    set_d(1, 0, 0, 0, 0, 3, 1, 1);
    cycle("hold_ld");
    for (int k = 0; k < 3; k++) begin
      set_d(1, 3, 1, 0, 0, 6, 1, 0);
      gwe = 0;
      cycle("hold");
      check("hold.valid", o_x_valid, 1);
      check("hold.rd", o_x_rd, 3);
      check("hold.cnt", o_stall_cnt, 16'd2);
    end
    check("hold.stall", o_stall, 1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      randomize_inputs();
      cycle("rnd");
    end

    // reset asserted mid-stall
    set_d(1, 0, 0, 0, 0, 2, 1, 1);
    cycle("mr_ld");
    set_d(1, 0, 0, 2, 1, 1, 1, 0);
    #3;
    check("mr.stall_pre", o_stall, 1);
    rst = 0;
    #1;
    model_reset();
    check("mr.stall", o_stall, 0);
    check("mr.valid", o_x_valid, 0);
    check("mr.insn", o_x_insn, 16'h0000);
    check("mr.cnt", o_stall_cnt, 0);
    @(posedge clk); #1;
    check_outputs("mr_held");
    rst = 1;
    set_d(1, 0, 0, 0, 0, 7, 1, 0);
    cycle("mr_first");

    // saturation
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 16'hFFFE;
    check("sat.preload", o_stall_cnt, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      set_d(1, 0, 0, 0, 0, 4, 1, 1);
      cycle("sat_ld");
      set_d(1, 4, 1, 0, 0, 1, 1, 0);
      cycle("sat_use");
      check("sat.cnt", o_stall_cnt, 16'hFFFF);
    end
    set_d(1, 0, 0, 0, 0, 1, 0, 0);
    cycle("sat_after");
    check("sat.stay", o_stall_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
